req_debounce: RTL and testbench

REQ_DEBOUNCE -- requirements
Module: req_debounce

---
 rtl/req_debounce.sv | 106 ++++++++++
 tb/tb_req_debounce.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/req_debounce.sv
// req_debounce: two-flop synchronizer plus stability qualifier for a request vector,
// with follow/sticky-OR output modes and a one-cycle update pulse. Rev 1.0
`default_nettype none

module req_debounce #(
  parameter int  OUTPUT_LEN = 2,
  parameter int  DEB_CYCLES = 4,
  localparam int W          = 1 << OUTPUT_LEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw,
  input  logic         en_in,
  input  logic         latch_mode,
  input  logic         clr,
  output logic [W-1:0] x,
  output logic         en,
  output logic         upd,
  output logic         busy
);

  localparam int              CNT_W      = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [0:0]      S_IDLE     = 1'b0;
  localparam logic [0:0]      S_COUNT    = 1'b1;

  logic [W-1:0]     r_sw_s1, r_sw_s2;
  logic             r_en_s1, r_en_s2;
  logic [W-1:0]     r_cand, r_stable, r_x;
  logic [CNT_W-1:0] r_cnt;
  logic [0:0]       r_state;
  logic             r_upd;

  logic [0:0]       w_state_nxt;
  logic [W-1:0]     w_cand_nxt, w_stable_nxt, w_x_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_en_s1  <= 1'b0;
      r_en_s2  <= 1'b0;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
      r_x      <= '0;
      r_upd    <= 1'b0;
      r_state  <= S_IDLE;
    end else begin
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
      r_en_s1  <= en_in;
      r_en_s2  <= r_en_s1;
      r_cand   <= w_cand_nxt;
      r_cnt    <= w_cnt_nxt;
      r_stable <= w_stable_nxt;
      r_x      <= w_x_nxt;
      r_upd    <= (w_x_nxt != r_x);
      r_state  <= w_state_nxt;
    end
  end

  // A new synchronized pattern always restarts qualification, even mid-count.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    if (r_sw_s2 != r_cand) begin
      w_cand_nxt  = r_sw_s2;
      w_cnt_nxt   = '0;
      w_state_nxt = S_COUNT;
    end else if (r_state == S_COUNT) begin
      if (r_cnt == C_CNT_LAST) begin
        w_accept    = 1'b1;
        w_state_nxt = S_IDLE;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_stable_nxt = w_accept ? r_cand : r_stable;
    w_x_nxt      = r_x;
    busy         = (r_state == S_COUNT);
    if (latch_mode) begin
      // Clear-with-accept loads the new pattern alone rather than OR-ing with old x.
      if (w_accept)
        w_x_nxt = clr ? r_cand : (r_x | r_cand);
      else if (clr)
        w_x_nxt = '0;
    end else if (w_accept) begin
      w_x_nxt = w_stable_nxt;
    end
  end

  assign x   = r_x;
  assign en  = r_en_s2;
  assign upd = r_upd;

endmodule

`default_nettype wire

// File: tb/tb_req_debounce.sv
// tb_req_debounce: directed table-driven checks of req_debounce at default parameters.
`default_nettype none

module tb_req_debounce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'h0;
  logic       en_in = 1'b0;
  logic       latch_mode = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] x;
  logic       en, upd, busy;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] sw;
    logic       en_in;
    logic       lm;
    logic       clr;
    logic [3:0] x;
    logic       en;
    logic       upd;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  req_debounce #(.OUTPUT_LEN(2), .DEB_CYCLES(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .en_in      (en_in),
    .latch_mode (latch_mode),
    .clr        (clr),
    .x          (x),
    .en         (en),
    .upd        (upd),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    else
      n_pass++;
  endtask

  // Append n identical rows: inputs applied, one edge, then outputs compared.
  task automatic add(input int n, input logic r, input logic [3:0] s, input logic e_in,
                     input logic lm, input logic c, input logic [3:0] ex,
                     input logic een, input logic eupd, input logic ebusy);
    vec_t v;
    v.rst_n = r; v.sw = s; v.en_in = e_in; v.lm = lm; v.clr = c;
    v.x = ex; v.en = een; v.upd = eupd; v.busy = ebusy;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    // reset
    add(2, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0);
    // glitch: 0010 for 3 cycles, then back to 0 (the 0 re-qualifies silently)
    add(2, 1, 4'h2, 0, 0, 0, 4'h0, 0, 0, 0);
    add(1, 1, 4'h2, 0, 0, 0, 4'h0, 0, 0, 1);
    add(6, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1);
    add(2, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0);
    // 0100 held: accepted 6 edges after the first sampling edge
    add(2, 1, 4'h4, 0, 0, 0, 4'h0, 0, 0, 0);
    add(4, 1, 4'h4, 0, 0, 0, 4'h0, 0, 0, 1);
    add(1, 1, 4'h4, 0, 0, 0, 4'h4, 0, 1, 0);
    add(1, 1, 4'h4, 0, 0, 0, 4'h4, 0, 0, 0);
    // switch to latch mode (x unchanged), then clear
    add(1, 1, 4'h4, 0, 1, 0, 4'h4, 0, 0, 0);
    add(1, 1, 4'h4, 0, 1, 1, 4'h0, 0, 1, 0);
    // sticky: 0001 then 1000 -> 1001
    add(2, 1, 4'h1, 0, 1, 0, 4'h0, 0, 0, 0);
    add(4, 1, 4'h1, 0, 1, 0, 4'h0, 0, 0, 1);
    add(1, 1, 4'h1, 0, 1, 0, 4'h1, 0, 1, 0);
    add(2, 1, 4'h8, 0, 1, 0, 4'h1, 0, 0, 0);
    add(4, 1, 4'h8, 0, 1, 0, 4'h1, 0, 0, 1);
    add(1, 1, 4'h8, 0, 1, 0, 4'h9, 0, 1, 0);
    add(1, 1, 4'h8, 0, 1, 1, 4'h0, 0, 1, 0);
    add(1, 1, 4'h8, 0, 1, 0, 4'h0, 0, 0, 0);
    // load 0010, then accept 0100 together with clr -> 0100
    add(2, 1, 4'h2, 0, 1, 0, 4'h0, 0, 0, 0);
    add(4, 1, 4'h2, 0, 1, 0, 4'h0, 0, 0, 1);
    add(1, 1, 4'h2, 0, 1, 0, 4'h2, 0, 1, 0);
    add(1, 1, 4'h4, 1, 1, 0, 4'h2, 0, 0, 0);
    add(1, 1, 4'h4, 1, 1, 0, 4'h2, 1, 0, 0);
    add(4, 1, 4'h4, 1, 1, 0, 4'h2, 1, 0, 1);
    add(1, 1, 4'h4, 1, 1, 1, 4'h4, 1, 1, 0);
    add(1, 1, 4'h4, 1, 1, 0, 4'h4, 1, 0, 0);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; sw = vecs[i].sw; en_in = vecs[i].en_in;
      latch_mode = vecs[i].lm; clr = vecs[i].clr;
      tick();
      chk("x", i, x, vecs[i].x);
      chk("en", i, {3'b0, en}, {3'b0, vecs[i].en});
      chk("upd", i, {3'b0, upd}, {3'b0, vecs[i].upd});
      chk("busy", i, {3'b0, busy}, {3'b0, vecs[i].busy});
    end

    // reset in the middle of qualifying 1111, then fresh qualification after release
    latch_mode = 1'b0;
    sw = 4'hF;
    tick();
    tick();
    tick();
    chk("rq_busy_pre", 0, {3'b0, busy}, 4'h1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("rq_x_rst", 0, x, 4'h0);
    chk("rq_busy_rst", 0, {3'b0, busy}, 4'h0);
    chk("rq_en_rst", 0, {3'b0, en}, 4'h0);
    chk("rq_upd_rst", 0, {3'b0, upd}, 4'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("rq_x", i, x, (i == 6) ? 4'hF : 4'h0);
      chk("rq_upd", i, {3'b0, upd}, (i == 6) ? 4'h1 : 4'h0);
      chk("rq_en", i, {3'b0, en}, (i >= 1) ? 4'h1 : 4'h0);
      chk("rq_busy", i, {3'b0, busy}, (i >= 2 && i <= 5) ? 4'h1 : 4'h0);
    end
    tick();
    chk("rq_upd_drop", 0, {3'b0, upd}, 4'h0);
    chk("rq_x_hold", 0, x, 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
